// File: rtl/logic_op_sequencer_pkg.sv
// Shared definitions for the logic-unit sequencer: op codes, FSM states, operand-count helper.
package logic_ops_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_INV  = 3'b111;

    // Op codes with both upper bits set (NOT, INV) take only the A word.
    localparam logic [2:0] SINGLE_OP_MASK = 3'b110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        EXEC   = 2'd2,
        RESP   = 2'd3
    } seq_state_t;

    function automatic logic is_single_op(input logic [2:0] ctrl);
        return (ctrl & SINGLE_OP_MASK) == SINGLE_OP_MASK;
    endfunction

endpackage

// File: rtl/logic_op_sequencer_if.sv
// Operand input stream plus result output stream of the sequencer.
interface logic_op_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic             out_err;
    logic [2:0]       out_ctrl;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_y, out_zero, out_err, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_y, out_zero, out_err, out_ctrl
    );
endinterface

// File: rtl/logic_op_sequencer.sv
// Registers operands for the external logic unit and returns its captured result; A->valid is 3 cycles
// (2 for single-operand ops); one op in flight, no input accepted while a result waits on out_ready.
module logic_op_sequencer
    import logic_ops_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    logic_op_sequencer_if.slave bus,
    output logic [WIDTH-1:0]  lu_a,
    output logic [WIDTH-1:0]  lu_b,
    output logic [2:0]        lu_ctrl,
    input  logic [WIDTH-1:0]  lu_y,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, y_q;
    logic [2:0]       ctrl_q, out_ctrl_q;
    logic             zero_q, err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_c, out_valid_c;
    logic [WIDTH-1:0] exec_y;

    // The logic unit's output for the unsupported code is meaningless, so it is masked.
    assign exec_y = (ctrl_q == OP_INV) ? '0 : lu_y;

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid)
                    state_d = is_single_op(bus.in_ctrl) ? EXEC : WAIT_B;
            end
            WAIT_B: begin
                in_ready_c = 1'b1;
                if (bus.in_valid)
                    state_d = EXEC;
            end
            EXEC: state_d = RESP;
            RESP: begin
                out_valid_c = 1'b1;
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            ctrl_q     <= '0;
            y_q        <= '0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
            out_ctrl_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q    <= bus.in_data;
                        ctrl_q <= bus.in_ctrl;
                        if (is_single_op(bus.in_ctrl))
                            b_q <= '0;
                    end
                end
                WAIT_B: begin
                    if (bus.in_valid)
                        b_q <= bus.in_data;
                end
                EXEC: begin
                    y_q        <= exec_y;
                    zero_q     <= (exec_y == '0);
                    err_q      <= (ctrl_q == OP_INV);
                    out_ctrl_q <= ctrl_q;
                end
                RESP: begin
                    if (bus.out_ready && cnt_q != CNT_MAX)
                        cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_y     = y_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_err   = err_q;
    assign bus.out_ctrl  = out_ctrl_q;
    assign lu_a          = a_q;
    assign lu_b          = b_q;
    assign lu_ctrl       = ctrl_q;
    assign op_count      = cnt_q;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Bench for logic_op_sequencer with a behavioural logic unit and a transaction-level scoreboard.
module tb_logic_op_sequencer;
    import logic_ops_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] lu_a, lu_b, lu_y;
    logic [2:0]       lu_ctrl;
    logic [CNT_W-1:0] op_count;

    logic_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

    logic_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .lu_a(lu_a), .lu_b(lu_b), .lu_ctrl(lu_ctrl), .lu_y(lu_y), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Stand-in for the 4-bit logic unit; it returns junk for the unsupported code.
    always_comb begin
        lu_y = 4'b1010;
        case (lu_ctrl)
            3'b000: lu_y = lu_a & lu_b;
            3'b001: lu_y = ~(lu_a & lu_b);
            3'b010: lu_y = lu_a | lu_b;
            3'b011: lu_y = ~(lu_a | lu_b);
            3'b100: lu_y = lu_a ^ lu_b;
            3'b101: lu_y = ~(lu_a ^ lu_b);
            3'b110: lu_y = ~lu_a;
            default: lu_y = 4'b1010;
        endcase
    end

    typedef struct {
        logic [WIDTH-1:0] y;
        logic             z;
        logic             e;
        logic [2:0]       c;
    } exp_t;

    exp_t q[$];
    int   model_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   run_cmp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected result per the op table, from the operands the bench supplied.
    function automatic exp_t model_op(input logic [2:0] c, input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
        exp_t r;
        int   ai, bi, yi;
        ai = int'(a);
        bi = int'(b);
        case (c)
            3'b000: yi = ai & bi;
            3'b001: yi = 15 - (ai & bi);
            3'b010: yi = ai | bi;
            3'b011: yi = 15 - (ai | bi);
            3'b100: yi = ai ^ bi;
            3'b101: yi = 15 - (ai ^ bi);
            3'b110: yi = 15 - ai;
            default: yi = 0;
        endcase
        r.y = WIDTH'(yi);
        r.z = (yi == 0);
        r.e = (c == 3'b111);
        r.c = c;
        return r;
    endfunction

    // Scoreboard: checks every cycle a result is presented and tracks the saturating count.
    always @(negedge clk) begin
        if (!rst && run_cmp) begin
            chk("op_count", 32'(op_count), 32'(model_cnt));
            if (bus.out_valid) begin
                chk("in_ready_in_resp", 32'(bus.in_ready), 32'd0);
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result: out_valid=1 with no op outstanding (t=%0t)", $time);
                end else begin
                    chk("sb_out_y", 32'(bus.out_y), 32'(q[0].y));
                    chk("sb_out_zero", 32'(bus.out_zero), 32'(q[0].z));
                    chk("sb_out_err", 32'(bus.out_err), 32'(q[0].e));
                    chk("sb_out_ctrl", 32'(bus.out_ctrl), 32'(q[0].c));
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        if (model_cnt < CNT_MAX) model_cnt++;
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [WIDTH-1:0] d, input logic [2:0] c);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_ctrl  = c;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 50) begin
                chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom_range(0, 15);
        bus.in_ctrl  = $urandom_range(0, 7);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] c, input int gap);
        send_word(a, c);
        if (!is_single_op(c)) begin
            repeat (gap) begin @(posedge clk); #1; end
            send_word(b, 3'($urandom_range(0, 7)));
        end
        q.push_back(model_op(c, a, is_single_op(c) ? '0 : b));
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        #3 rst = 1'b1;
        q.delete();
        model_cnt = 0;
        bus.in_valid = 1'b0;
        #4 rst = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_y"}, 32'(bus.out_y), 32'd0);
        chk({tag, "_flags"}, {30'd0, bus.out_zero, bus.out_err}, 32'd0);
        chk({tag, "_out_ctrl"}, 32'(bus.out_ctrl), 32'd0);
        chk({tag, "_lu"}, {20'd0, lu_a, lu_b, 1'b0, lu_ctrl}, 32'd0);
        chk({tag, "_op_count"}, 32'(op_count), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rnd_rdy;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_ctrl   = '0;
        bus.out_ready = 1'b1;
        #12 rst = 1'b0;
        @(posedge clk); #1;
        run_cmp = 1'b1;
        check_idle_zero("reset");

        // Unsupported op: masked result, error flag, still counted.
        do_op(4'b1111, 4'b0000, OP_INV, 0);
        wait_valid("inv_valid");
        chk("inv_y", 32'(bus.out_y), 32'd0);
        chk("inv_flags", {29'd0, bus.out_zero, bus.out_err, 1'b0}, 32'b110);
        chk("inv_ctrl", 32'(bus.out_ctrl), 32'b111);
        @(negedge clk);
        chk("inv_count", 32'(op_count), 32'd1);
        @(posedge clk); #1;

        // AND, B back-to-back: valid exactly 3 cycles after A.
        send_word(4'b1100, OP_AND);
        send_word(4'b1010, 3'b111);
        q.push_back(model_op(OP_AND, 4'b1100, 4'b1010));
        @(negedge clk);
        chk("and_exec_valid", 32'(bus.out_valid), 32'd0);
        chk("and_exec_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("and_lat3_valid", 32'(bus.out_valid), 32'd1);
        chk("and_y", 32'(bus.out_y), 32'b1000);
        chk("and_flags", {29'd0, bus.out_zero, bus.out_err, 1'b0}, 32'd0);
        chk("and_ctrl", 32'(bus.out_ctrl), 32'd0);
        @(posedge clk); #1;

        do_op(4'b0110, 4'b0110, OP_XOR, 0);
        wait_valid("xor_valid");
        chk("xor_y", 32'(bus.out_y), 32'b0000);
        chk("xor_zero", 32'(bus.out_zero), 32'd1);
        @(posedge clk); #1;
        do_op(4'b0110, 4'b0110, OP_XNOR, 2);
        wait_valid("xnor_valid");
        chk("xnor_y", 32'(bus.out_y), 32'b1111);
        chk("xnor_zero", 32'(bus.out_zero), 32'd0);
        @(posedge clk); #1;

        // NOT under backpressure: valid 2 cycles after A, then held for 5 cycles.
        bus.out_ready = 1'b0;
        send_word(4'b0101, OP_NOT);
        q.push_back(model_op(OP_NOT, 4'b0101, 4'b0000));
        @(negedge clk);
        chk("not_exec_ready", 32'(bus.in_ready), 32'd0);
        chk("not_exec_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("not_lat2_valid", 32'(bus.out_valid), 32'd1);
        chk("not_lu_b", 32'(lu_b), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_y", 32'(bus.out_y), 32'b1010);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_count", 32'(op_count), 32'd3);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_released", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset while waiting for B.
        send_word(4'b0011, OP_OR);
        apply_reset();
        check_idle_zero("midreset");
        do_op(4'b0011, 4'b0100, OP_OR, 0);
        wait_valid("or_valid");
        chk("or_y", 32'(bus.out_y), 32'b0111);
        @(negedge clk);
        chk("or_count", 32'(op_count), 32'd1);
        @(posedge clk); #1;

        // Saturation: five ops on a 2-bit counter.
        apply_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++)
            do_op(4'(i), 4'(i + 3), 3'(i), 0);
        drain();
        chk("sat_count", 32'(op_count), 32'd3);

        // Randomized ops, gaps and backpressure.
        apply_reset();
        @(posedge clk); #1;
        rnd_rdy = 1'b1;
        fork
            while (rnd_rdy) begin
                @(posedge clk); #1;
                bus.out_ready = ($urandom_range(0, 2) != 0);
            end
        join_none
        for (int i = 0; i < 200; i++) begin
            do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  3'($urandom_range(0, 7)), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        drain();
        rnd_rdy = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("final_count", 32'(op_count), 32'(CNT_MAX));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
